gs_column_update: RTL

Sequential, parametrised Gram-Schmidt column-update engine for the QR-based MIMO detector. It computes the projection-removed column v_i = H_i − (R·Q_i)/SCALE for N complex elements, using one shared complex multiplier and scaler, and processes one element per cycle. It sits between the R-coefficient stage and the norm/normalise stage of the QR decomposition. It replaces the fixed 2-element combinational update with a valid/ready handshake, selectable overflow handling and an overflow flag.

---
 rtl/gs_column_update.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gs_column_update.sv
// Gram-Schmidt column update: v_i = H_i - (R*Q_i)/SCALE, one complex element per cycle,
// with a shared multiplier/divider and a valid/ready handshake on both sides.
module gs_column_update #(
  parameter int W     = 28,
  parameter int N     = 2,
  parameter int SCALE = 1000,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     r_real,
  input  logic [W-1:0]     r_imag,
  input  logic [N*W-1:0]   q_real,
  input  logic [N*W-1:0]   q_imag,
  input  logic [N*W-1:0]   h_real,
  input  logic [N*W-1:0]   h_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   v_real,
  output logic [N*W-1:0]   v_imag,
  output logic             ovf
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready comes from the state register alone.
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic signed [2*W-1:0] SCALE_S = (2*W)'(SCALE);
  localparam logic signed [2*W:0] MAX_S = {{(W+1){1'b0}}, 1'b0, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MIN_S = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [W-1:0]        rr_q, rr_d, ri_q, ri_d;
  logic [N*W-1:0]      qr_q, qr_d, qi_q, qi_d;
  logic [N*W-1:0]      hr_q, hr_d, hi_q, hi_d;
  logic [N*W-1:0]      vr_q, vr_d, vi_q, vi_d;
  logic                ovf_q, ovf_d;

  logic [W-1:0]            qr_e, qi_e, hr_e, hi_e;
  logic signed [2*W-1:0]   rr_x, ri_x, qr_x, qi_x;
  logic signed [2*W-1:0]   p_re, p_im, d_re, d_im;
  logic signed [2*W:0]     s_re, s_im;
  logic                    ov_re, ov_im;

  function automatic logic [W-1:0] fit(input logic signed [2*W:0] s);
    if (SAT != 0 && s > MAX_S) return MAX_S[W-1:0];
    if (SAT != 0 && s < MIN_S) return MIN_S[W-1:0];
    return s[W-1:0];
  endfunction

  // Datapath for the element selected by idx_q; operands sign-extended to 2W bits.
  always_comb begin
    qr_e  = qr_q[idx_q*W +: W];
    qi_e  = qi_q[idx_q*W +: W];
    hr_e  = hr_q[idx_q*W +: W];
    hi_e  = hi_q[idx_q*W +: W];
    rr_x  = {{W{rr_q[W-1]}}, rr_q};
    ri_x  = {{W{ri_q[W-1]}}, ri_q};
    qr_x  = {{W{qr_e[W-1]}}, qr_e};
    qi_x  = {{W{qi_e[W-1]}}, qi_e};
    p_re  = rr_x * qr_x - ri_x * qi_x;
    p_im  = rr_x * qi_x + ri_x * qr_x;
    d_re  = p_re / SCALE_S;
    d_im  = p_im / SCALE_S;
    s_re  = {{(W+1){hr_e[W-1]}}, hr_e} - {d_re[2*W-1], d_re};
    s_im  = {{(W+1){hi_e[W-1]}}, hi_e} - {d_im[2*W-1], d_im};
    ov_re = (s_re > MAX_S) || (s_re < MIN_S);
    ov_im = (s_im > MAX_S) || (s_im < MIN_S);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    ri_d    = ri_q;
    qr_d    = qr_q;
    qi_d    = qi_q;
    hr_d    = hr_q;
    hi_d    = hi_q;
    vr_d    = vr_q;
    vi_d    = vi_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rr_d    = r_real;
          ri_d    = r_imag;
          qr_d    = q_real;
          qi_d    = q_imag;
          hr_d    = h_real;
          hi_d    = h_imag;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        vr_d[idx_q*W +: W] = fit(s_re);
        vi_d[idx_q*W +: W] = fit(s_im);
        if (ov_re || ov_im) ovf_d = 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      ri_q    <= '0;
      qr_q    <= '0;
      qi_q    <= '0;
      hr_q    <= '0;
      hi_q    <= '0;
      vr_q    <= '0;
      vi_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      ri_q    <= ri_d;
      qr_q    <= qr_d;
      qi_q    <= qi_d;
      hr_q    <= hr_d;
      hi_q    <= hi_d;
      vr_q    <= vr_d;
      vi_q    <= vi_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign v_real    = vr_q;
  assign v_imag    = vi_q;
  assign ovf       = ovf_q;

endmodule
